frame_tx: RTL and testbench

FRAME_TX -- requirements
Module: frame_tx

---
 rtl/frame_tx.sv | 212 +++++++++++++++++++++
 tb/tb_frame_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : frame_tx
//  Purpose  : Buffers raster-order pixels from a valid/ready stream and
//             replays them as one frame on a registered frame bus, with a
//             programmable idle gap between lines.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_tx #(
   parameter int DATA_WIDTH  = 8,
   parameter int FRAME_H_MAX = 64,
   parameter int FRAME_W_MAX = 64,
   parameter int FIFO_DEPTH  = 8,
   parameter int GAP_MAX     = 255
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [$clog2(FRAME_H_MAX+1)-1:0]    frame_h,
   input  logic [$clog2(FRAME_W_MAX+1)-1:0]    frame_w,
   input  logic [$clog2(GAP_MAX+1)-1:0]        line_gap,
   input  logic                                s_valid,
   output logic                                s_ready,
   input  logic [DATA_WIDTH-1:0]               s_data,
   output logic                                fout_start,
   output logic                                dout_vld,
   output logic [DATA_WIDTH-1:0]               dout,
   output logic                                busy,
   output logic                                done
);

   localparam int c_hw = $clog2(FRAME_H_MAX+1);
   localparam int c_ww = $clog2(FRAME_W_MAX+1);
   localparam int c_gw = $clog2(GAP_MAX+1);
   localparam int c_tw = $clog2(FRAME_H_MAX*FRAME_W_MAX+1);
   localparam int c_aw = $clog2(FIFO_DEPTH);
   localparam int c_cw = c_aw + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_GAP    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [c_hw-1:0]        h_q, h_d;
   logic [c_ww-1:0]        w_q, w_d;
   logic [c_gw-1:0]        gap_q, gap_d;
   logic [c_tw-1:0]        total_q, total_d;
   logic [c_tw-1:0]        in_cnt_q, in_cnt_d;
   logic [c_hw-1:0]        row_q, row_d;
   logic [c_ww-1:0]        col_q, col_d;
   logic [c_gw-1:0]        gap_cnt_q, gap_cnt_d;
   logic [c_aw-1:0]        wr_ptr_q, wr_ptr_d;
   logic [c_aw-1:0]        rd_ptr_q, rd_ptr_d;
   logic [c_cw-1:0]        count_q, count_d;
   logic [DATA_WIDTH-1:0]  dout_q, dout_d;
   logic                   dout_vld_q, dout_vld_d;
   logic                   fout_start_q, fout_start_d;
   logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

   logic w_busy;
   logic w_full;
   logic w_empty;
   logic w_ready;
   logic w_push;
   logic w_pop;

   // Handshake qualifiers: input is only taken while a frame is in flight and
   // never beyond the number of pixels the frame needs.
   always_comb begin
      w_busy  = (state_q != S_IDLE);
      w_full  = (count_q == c_cw'(FIFO_DEPTH));
      w_empty = (count_q == '0);
      w_ready = w_busy && !w_full && (in_cnt_q < total_q);
      w_push  = s_valid && w_ready;
      w_pop   = (state_q == S_ACTIVE) && !w_empty;
   end

   // Pixel storage; contents are don't-care until pushed, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         h_q          <= '0;
         w_q          <= '0;
         gap_q        <= '0;
         total_q      <= '0;
         in_cnt_q     <= '0;
         row_q        <= '0;
         col_q        <= '0;
         gap_cnt_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_vld_q   <= 1'b0;
         fout_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         h_q          <= h_d;
         w_q          <= w_d;
         gap_q        <= gap_d;
         total_q      <= total_d;
         in_cnt_q     <= in_cnt_d;
         row_q        <= row_d;
         col_q        <= col_d;
         gap_cnt_q    <= gap_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_vld_q   <= dout_vld_d;
         fout_start_q <= fout_start_d;
      end
   end

   // Next-state, raster position tracking and FIFO bookkeeping.
   always_comb begin
      state_d      = state_q;
      h_d          = h_q;
      w_d          = w_q;
      gap_d        = gap_q;
      total_d      = total_q;
      in_cnt_d     = in_cnt_q;
      row_d        = row_q;
      col_d        = col_q;
      gap_cnt_d    = gap_cnt_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_vld_d   = 1'b0;
      fout_start_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && (frame_h != '0) && (frame_w != '0)) begin
               h_d      = frame_h;
               w_d      = frame_w;
               gap_d    = line_gap;
               total_d  = c_tw'(frame_h) * c_tw'(frame_w);
               in_cnt_d = '0;
               row_d    = '0;
               col_d    = '0;
               state_d  = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (w_pop) begin
               dout_d       = mem_q[rd_ptr_q];
               dout_vld_d   = 1'b1;
               fout_start_d = (row_q == '0) && (col_q == '0);
               if (col_q == w_q - c_ww'(1)) begin
                  col_d = '0;
                  if (row_q == h_q - c_hw'(1)) begin
                     state_d = S_DONE;
                  end else begin
                     row_d     = row_q + c_hw'(1);
                     gap_cnt_d = '0;
                     if (gap_q != '0) begin
                        state_d = S_GAP;
                     end
                  end
               end else begin
                  col_d = col_q + c_ww'(1);
               end
            end
         end
         S_GAP: begin
            // gap_cnt counts the idle cycles already spent in this gap.
            if (gap_cnt_q == gap_q - c_gw'(1)) begin
               state_d = S_ACTIVE;
            end else begin
               gap_cnt_d = gap_cnt_q + c_gw'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (w_push) begin
         wr_ptr_d = wr_ptr_q + c_aw'(1);
         in_cnt_d = in_cnt_q + c_tw'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_aw'(1);
      end
      if (w_push && !w_pop) begin
         count_d = count_q + c_cw'(1);
      end else if (!w_push && w_pop) begin
         count_d = count_q - c_cw'(1);
      end
   end

   assign s_ready    = w_ready;
   assign busy       = w_busy;
   assign done       = (state_q == S_DONE);
   assign dout       = dout_q;
   assign dout_vld   = dout_vld_q;
   assign fout_start = fout_start_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_tx
//  Purpose  : Randomised, scoreboard-checked bench for frame_tx.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [6:0] frame_h;
   logic [6:0] frame_w;
   logic [7:0] line_gap;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       fout_start;
   logic       dout_vld;
   logic [7:0] dout;
   logic       busy;
   logic       done;

   frame_tx dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .frame_h    (frame_h),
      .frame_w    (frame_w),
      .line_gap   (line_gap),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .fout_start (fout_start),
      .dout_vld   (dout_vld),
      .dout       (dout),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         fs;
      bit         dn;
      int         row;
      int         col;
   } exp_t;

   exp_t       sb[$];
   int         tests = 0;
   int         fails = 0;
   int         frames_done = 0;
   int         out_cnt = 0;
   int         cur_gap = 0;
   bit         exact_gap = 1'b0;
   int         mon_cyc = 0;
   int         last_vld_cyc = 0;
   int         idx = 0;
   int         cyc = 0;
   int         mode = 0;
   int         avail = 0;
   logic [7:0] src [0:63];
   exp_t       me;
   int         mgap;

   task automatic chk(input string nm, input bit ok, input longint act, input longint expv);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Monitor: every presented pixel is matched against the head of the scoreboard.
   always @(negedge clk) begin
      mon_cyc++;
      if (!reset) begin
         if (dout_vld) begin
            mgap = mon_cyc - last_vld_cyc - 1;
            if (sb.size() == 0) begin
               chk("extra_pixel", 1'b0, longint'(dout), -1);
            end else begin
               me = sb.pop_front();
               chk("dout", dout == me.d, longint'(dout), longint'(me.d));
               chk("fout_start", fout_start == me.fs, longint'(fout_start), longint'(me.fs));
               chk("done", done == me.dn, longint'(done), longint'(me.dn));
               if (me.col == 0 && me.row > 0) begin
                  chk("line_gap", exact_gap ? (mgap == cur_gap) : (mgap >= cur_gap),
                      longint'(mgap), longint'(cur_gap));
               end else if (me.col > 0 && exact_gap) begin
                  chk("row_contiguous", mgap == 0, longint'(mgap), 0);
               end
               if (me.dn) frames_done++;
            end
            out_cnt++;
            last_vld_cyc = mon_cyc;
         end else if (fout_start || done) begin
            chk("strobe_without_valid", 1'b0, longint'({fout_start, done}), 0);
         end
      end
   end

   // One clock of upstream behaviour: account the handshake, then offer the next pixel.
   task automatic tick();
      bit hs;
      bit v;
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (hs) idx++;
      cyc++;
      case (mode)
         0:       v = 1'b1;
         1:       v = cyc[0];
         default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v && (idx < avail);
      s_data  = (idx < 64) ? src[idx] : 8'h00;
   endtask

   task automatic load_frame(input int h, input int w, input int g, input int m, input int av);
      int total;
      total = h * w;
      mode  = m;
      avail = av;
      idx   = 0;
      for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
      s_data    = src[0];
      s_valid   = 1'b0;
      cur_gap   = g;
      exact_gap = (m == 0);
      frame_h   = 7'(h);
      frame_w   = 7'(w);
      line_gap  = 8'(g);
      for (int k = 0; k < total; k++)
         sb.push_back('{d: src[k], fs: (k == 0), dn: (k == total - 1), row: k / w, col: k % w});
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy == 1'b1, longint'(busy), 1);
   endtask

   task automatic run_frame(input int h, input int w, input int g, input int m, input int av,
                            input int restart_at);
      int fd0;
      int t;
      fd0 = frames_done;
      load_frame(h, w, g, m, av);
      t = 0;
      while (frames_done == fd0 && t < 3000) begin
         if (t == restart_at) begin
            frame_h  = 7'd1;
            frame_w  = 7'd1;
            line_gap = 8'd0;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         t++;
      end
      start = 1'b0;
      chk("frame_completes", frames_done == fd0 + 1, longint'(frames_done - fd0), 1);
      repeat (4) tick();
      chk("busy_after_done", busy == 1'b0, longint'(busy), 0);
      chk("scoreboard_drained", sb.size() == 0, longint'(sb.size()), 0);
      chk("pixels_accepted", idx == h * w, longint'(idx), longint'(h * w));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int fd0;
      int t;
      reset    = 1'b1;
      start    = 1'b0;
      s_valid  = 1'b0;
      s_data   = 8'h00;
      frame_h  = 7'd0;
      frame_w  = 7'd0;
      line_gap = 8'd0;
      mode     = 0;
      avail    = 0;
      repeat (3) tick();
      chk("rst_dout_vld", dout_vld == 1'b0, longint'(dout_vld), 0);
      chk("rst_fout_start", fout_start == 1'b0, longint'(fout_start), 0);
      chk("rst_dout", dout == 8'h00, longint'(dout), 0);
      chk("rst_s_ready", s_ready == 1'b0, longint'(s_ready), 0);
      chk("rst_busy", busy == 1'b0, longint'(busy), 0);
      chk("rst_done", done == 1'b0, longint'(done), 0);
      reset = 1'b0;
      repeat (2) tick();

      // 3x4, no gap, continuous input
      run_frame(3, 4, 0, 0, 12, -1);
      // 2x3 with a two-cycle line gap
      run_frame(2, 3, 2, 0, 6, -1);
      // 4x4 with input valid every other cycle
      run_frame(4, 4, 0, 1, 16, -1);

      // zero width start must be ignored
      frame_h  = 7'd3;
      frame_w  = 7'd0;
      line_gap = 8'd0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      tick();
      chk("zero_width_busy", busy == 1'b0, longint'(busy), 0);
      chk("zero_width_ready", s_ready == 1'b0, longint'(s_ready), 0);

      // start pulsed mid-frame with different geometry must be ignored
      run_frame(4, 4, 1, 0, 16, 5);

      // reset after five output pixels
      fd0     = frames_done;
      out_cnt = 0;
      load_frame(4, 4, 1, 0, 16);
      t = 0;
      while (out_cnt < 5 && t < 200) begin
         tick();
         t++;
      end
      chk("five_pixels_before_reset", out_cnt >= 5, longint'(out_cnt), 5);
      reset = 1'b1;
      tick();
      chk("midrst_dout_vld", dout_vld == 1'b0, longint'(dout_vld), 0);
      chk("midrst_fout_start", fout_start == 1'b0, longint'(fout_start), 0);
      chk("midrst_dout", dout == 8'h00, longint'(dout), 0);
      chk("midrst_s_ready", s_ready == 1'b0, longint'(s_ready), 0);
      chk("midrst_busy", busy == 1'b0, longint'(busy), 0);
      chk("midrst_done", done == 1'b0, longint'(done), 0);
      chk("midrst_no_done_pulse", frames_done == fd0, longint'(frames_done - fd0), 0);
      sb.delete();
      reset = 1'b0;
      tick();
      run_frame(4, 4, 1, 0, 16, -1);

      // upstream offers more pixels than the frame needs
      run_frame(4, 4, 0, 0, 20, -1);
      chk("overflow_s_ready_low", s_ready == 1'b0, longint'(s_ready), 0);
      chk("overflow_s_valid_still_high", s_valid == 1'b1, longint'(s_valid), 1);

      // randomised geometry, gaps and input patterns
      for (int r = 0; r < 8; r++) begin
         int rh;
         int rw;
         rh = $urandom_range(1, 5);
         rw = $urandom_range(1, 6);
         run_frame(rh, rw, $urandom_range(0, 3), $urandom_range(0, 2), rh * rw, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
